// File: rtl/jpeg_block_scheduler.sv
// -----------------------------------------------------------------------------
// jpeg_block_scheduler
//
// Sequences the JPEG compression datapath one 8x8 block at a time:
//   FILL  : accepts RGB pixels from a valid/ready stream into the flat
//           r_all/g_all/b_all buses that feed the pipeline.
//   WAIT  : holds the buses stable for PIPE_LATENCY cycles while the
//           pipeline settles.
//   DRAIN : emits the pipeline's Y, Cb and Cr zigzag outputs as one
//           192-word valid/ready coefficient stream, then returns to FILL.
//
// Ports
//   clk, reset_n            : clock, asynchronous active-low reset
//   enable                  : permits pixel acceptance in FILL
//   soft_clr                : synchronous abort; back to FILL, counters cleared
//   s_pix_data/valid/ready  : pixel stream, {B, G, R}
//   r_all, g_all, b_all     : channel buses to the pipeline, pixel i at [IW*i +: IW]
//   y/cb/cr_zigzag          : pipeline outputs, word k at [DW*k +: DW]
//   m_coef_data/comp/valid/ready/last : coefficient stream (comp 0=Y,1=Cb,2=Cr)
//   busy                    : high in WAIT or DRAIN
//   block_done              : one-cycle pulse per completed block
//   block_count             : completed blocks, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module jpeg_block_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int INPUT_WIDTH  = 8,
  parameter int PIXEL_COUNT  = 64,
  parameter int PIPE_LATENCY = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic                              soft_clr,
  input  logic [3*INPUT_WIDTH-1:0]          s_pix_data,
  input  logic                              s_pix_valid,
  output logic                              s_pix_ready,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0] r_all,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0] g_all,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0] b_all,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0]  y_zigzag,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0]  cb_zigzag,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0]  cr_zigzag,
  output logic [DATA_WIDTH-1:0]             m_coef_data,
  output logic [1:0]                        m_coef_comp,
  output logic                              m_coef_valid,
  input  logic                              m_coef_ready,
  output logic                              m_coef_last,
  output logic                              busy,
  output logic                              block_done,
  output logic [CNT_WIDTH-1:0]              block_count
);

  localparam int PW = $clog2(PIXEL_COUNT);
  localparam int OW = $clog2(3 * PIXEL_COUNT);
  localparam int WW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

  localparam logic [PW-1:0] LP_PIX_LAST  = PW'(PIXEL_COUNT - 1);
  localparam logic [OW-1:0] LP_OUT_LAST  = OW'(3 * PIXEL_COUNT - 1);
  localparam logic [OW-1:0] LP_CB_BASE   = OW'(PIXEL_COUNT);
  localparam logic [OW-1:0] LP_CR_BASE   = OW'(2 * PIXEL_COUNT);
  // Offsets reduced modulo 2^PW: the word index fits in PW bits, so the
  // low bits of (out_idx - base) equal the difference of the low bits.
  localparam logic [PW-1:0] LP_CB_OFS    = PW'(PIXEL_COUNT);
  localparam logic [PW-1:0] LP_CR_OFS    = PW'(2 * PIXEL_COUNT);
  localparam logic [WW-1:0] LP_WAIT_INIT = WW'(PIPE_LATENCY - 1);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]                        r_state;
  logic [PW-1:0]                     r_pix_idx;
  logic [OW-1:0]                     r_out_idx;
  logic [WW-1:0]                     r_wait_cnt;
  logic                              r_armed;
  logic                              r_done;
  logic [CNT_WIDTH-1:0]              r_count;
  logic [INPUT_WIDTH*PIXEL_COUNT-1:0] r_rbuf;
  logic [INPUT_WIDTH*PIXEL_COUNT-1:0] r_gbuf;
  logic [INPUT_WIDTH*PIXEL_COUNT-1:0] r_bbuf;

  logic                  w_fill;
  logic                  w_drain;
  logic                  w_pix_hs;
  logic                  w_coef_hs;
  logic [1:0]            w_comp;
  logic [PW-1:0]         w_word_idx;
  logic [DATA_WIDTH-1:0] w_sel_data;

  assign w_fill  = (r_state == ST_FILL);
  assign w_drain = (r_state == ST_DRAIN);

  // r_armed keeps s_pix_ready low during reset and for the first cycle after
  // release, so every output really is 0 while reset is asserted.
  assign s_pix_ready = w_fill && enable && r_armed;
  assign w_pix_hs    = s_pix_valid && s_pix_ready;
  assign w_coef_hs   = m_coef_valid && m_coef_ready;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_comp     = 2'd0;
    w_word_idx = r_out_idx[PW-1:0];
    if (r_out_idx >= LP_CR_BASE) begin
      w_comp     = 2'd2;
      w_word_idx = r_out_idx[PW-1:0] - LP_CR_OFS;
    end else if (r_out_idx >= LP_CB_BASE) begin
      w_comp     = 2'd1;
      w_word_idx = r_out_idx[PW-1:0] - LP_CB_OFS;
    end
  end

  always_comb begin
    w_sel_data = y_zigzag[DATA_WIDTH*w_word_idx +: DATA_WIDTH];
    case (w_comp)
      2'd1:    w_sel_data = cb_zigzag[DATA_WIDTH*w_word_idx +: DATA_WIDTH];
      2'd2:    w_sel_data = cr_zigzag[DATA_WIDTH*w_word_idx +: DATA_WIDTH];
      default: w_sel_data = y_zigzag[DATA_WIDTH*w_word_idx +: DATA_WIDTH];
    endcase
  end

  // Stream outputs are forced to 0 outside DRAIN so idle and reset values are 0.
  assign m_coef_valid = w_drain;
  assign m_coef_data  = w_drain ? w_sel_data : '0;
  assign m_coef_comp  = w_drain ? w_comp : 2'd0;
  assign m_coef_last  = w_drain && (r_out_idx == LP_OUT_LAST);
  assign busy         = !w_fill;
  assign block_done   = r_done;
  assign block_count  = r_count;
  assign r_all        = r_rbuf;
  assign g_all        = r_gbuf;
  assign b_all        = r_bbuf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_FILL;
      r_pix_idx  <= '0;
      r_out_idx  <= '0;
      r_wait_cnt <= '0;
      r_done     <= 1'b0;
      r_count    <= '0;
    end else if (soft_clr) begin
      r_state    <= ST_FILL;
      r_pix_idx  <= '0;
      r_out_idx  <= '0;
      r_wait_cnt <= '0;
      r_done     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_FILL: begin
          if (w_pix_hs) begin
            if (r_pix_idx == LP_PIX_LAST) begin
              r_state    <= ST_WAIT;
              r_pix_idx  <= '0;
              r_wait_cnt <= LP_WAIT_INIT;
            end else begin
              r_pix_idx <= r_pix_idx + PW'(1);
            end
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state   <= ST_DRAIN;
            r_out_idx <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt - WW'(1);
          end
        end
        ST_DRAIN: begin
          if (w_coef_hs) begin
            if (r_out_idx == LP_OUT_LAST) begin
              r_state   <= ST_FILL;
              r_pix_idx <= '0;
              r_out_idx <= '0;
              r_done    <= 1'b1;
              r_count   <= r_count + CNT_WIDTH'(1);
            end else begin
              r_out_idx <= r_out_idx + OW'(1);
            end
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  // NOTE: the pixel buffers are wide storage, but they are reset anyway
  // because r/g/b_all must read 0 out of reset; soft_clr leaves them alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rbuf <= '0;
      r_gbuf <= '0;
      r_bbuf <= '0;
    end else if (w_pix_hs && !soft_clr) begin
      r_rbuf[INPUT_WIDTH*r_pix_idx +: INPUT_WIDTH] <= s_pix_data[INPUT_WIDTH-1:0];
      r_gbuf[INPUT_WIDTH*r_pix_idx +: INPUT_WIDTH] <= s_pix_data[2*INPUT_WIDTH-1:INPUT_WIDTH];
      r_bbuf[INPUT_WIDTH*r_pix_idx +: INPUT_WIDTH] <= s_pix_data[3*INPUT_WIDTH-1:2*INPUT_WIDTH];
    end
  end

endmodule

// File: tb/tb_jpeg_block_scheduler.sv
// -----------------------------------------------------------------------------
// tb_jpeg_block_scheduler
//
// Scoreboard bench: each filled block pushes its 192 expected coefficient
// words; an independent monitor pops and compares on every output handshake,
// checks hold-during-stall, and checks block_done / block_count.
// The DUT runs with CNT_WIDTH=2 so the block counter wraps quickly.
// -----------------------------------------------------------------------------
module tb_jpeg_block_scheduler;

  localparam int DW = 32;
  localparam int IW = 8;
  localparam int PC = 64;
  localparam int PL = 8;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              soft_clr;
  logic [3*IW-1:0]   s_pix_data;
  logic              s_pix_valid;
  logic              s_pix_ready;
  logic [IW*PC-1:0]  r_all, g_all, b_all;
  logic [DW*PC-1:0]  y_zz, cb_zz, cr_zz;
  logic [DW-1:0]     m_coef_data;
  logic [1:0]        m_coef_comp;
  logic              m_coef_valid;
  logic              m_coef_ready;
  logic              m_coef_last;
  logic              busy;
  logic              block_done;
  logic [CW-1:0]     block_count;

  logic [IW*PC-1:0]  exp_r, exp_g, exp_b;

  int          checks = 0;
  int          errors = 0;
  logic [34:0] exp_q[$];
  int          words_seen = 0;
  int          blocks_seen = 0;
  logic [CW-1:0] exp_cnt = '0;
  bit          expect_done = 1'b0;
  bit          rand_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [34:0] prev_word;
  logic [34:0] cur_word;
  logic [34:0] exp_word;

  jpeg_block_scheduler #(
    .DATA_WIDTH(DW), .INPUT_WIDTH(IW), .PIXEL_COUNT(PC),
    .PIPE_LATENCY(PL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .soft_clr(soft_clr),
    .s_pix_data(s_pix_data), .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready),
    .r_all(r_all), .g_all(g_all), .b_all(b_all),
    .y_zigzag(y_zz), .cb_zigzag(cb_zz), .cr_zigzag(cr_zz),
    .m_coef_data(m_coef_data), .m_coef_comp(m_coef_comp),
    .m_coef_valid(m_coef_valid), .m_coef_ready(m_coef_ready),
    .m_coef_last(m_coef_last), .busy(busy), .block_done(block_done),
    .block_count(block_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pipeline model and expected channel buses: Y k = k, Cb = 0x100+k, Cr = 0x200+k.
  initial begin
    for (int k = 0; k < PC; k++) begin
      y_zz[DW*k +: DW]  = DW'(k);
      cb_zz[DW*k +: DW] = DW'(32'h100 + k);
      cr_zz[DW*k +: DW] = DW'(32'h200 + k);
      exp_r[IW*k +: IW] = IW'(k);
      exp_g[IW*k +: IW] = IW'(2 * k);
      exp_b[IW*k +: IW] = IW'(3 * k);
    end
  end

  // Coefficient-side ready: always high, or 50% random in backpressure mode.
  initial begin
    m_coef_ready = 1'b1;
    forever begin
      @(negedge clk);
      m_coef_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples 2 time units after the falling edge, i.e. the values the
  // next rising edge will see.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n || soft_clr) begin
        prev_stall  = 1'b0;
        expect_done = 1'b0;
      end else begin
        cur_word = {m_coef_last, m_coef_comp, m_coef_data};
        if (expect_done) begin
          check("block_done_pulse", block_done, 1'b1);
          check("block_count", block_count, exp_cnt);
          check("ready_at_done", s_pix_ready, enable);
          blocks_seen++;
          expect_done = 1'b0;
        end else if (block_done) begin
          check("spurious_block_done", block_done, 1'b0);
        end
        if (prev_stall)
          check("stall_hold", {m_coef_valid, cur_word}, {1'b1, prev_word});
        if (m_coef_valid && m_coef_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_word", cur_word, '0);
          end else begin
            exp_word = exp_q.pop_front();
            check("coef_word", cur_word, exp_word);
            words_seen++;
            if (exp_word[34]) begin
              expect_done = 1'b1;
              exp_cnt     = exp_cnt + 1'b1;
              words_seen  = 0;
            end
          end
        end
        prev_stall = m_coef_valid && !m_coef_ready;
        prev_word  = cur_word;
      end
    end
  end

  // Fill one block; pushes its expected output words first. Starts and ends
  // on a falling edge.
  task automatic fill_block(input bit gaps, input bit drop_en, input bit lat);
    int i = 0;
    int guard = 0;
    int n;
    bit dropped = 1'b0;
    for (int k = 0; k < 3 * PC; k++)
      exp_q.push_back({(k == 3 * PC - 1), 2'(k / PC), 32'((k / PC) * 256 + k % PC)});
    while (i < PC && guard < 4000) begin
      if (drop_en && i == 30 && !dropped) begin
        enable      = 1'b0;
        s_pix_valid = 1'b1;
        s_pix_data  = 24'hFFFFFF;
        #2 check("ready_drop_same_cycle", s_pix_ready, 1'b0);
        repeat (3) @(negedge clk);
        #2 check("ready_held_low", s_pix_ready, 1'b0);
        @(negedge clk);
        enable  = 1'b1;
        dropped = 1'b1;
      end
      s_pix_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_pix_data  = {8'(3 * i), 8'(2 * i), 8'(i)};
      #2;
      if (s_pix_valid && s_pix_ready) i++;
      @(negedge clk);
      guard++;
    end
    s_pix_valid = 1'b0;
    if (i < PC) check("fill_timeout", i, PC);
    #2;
    check("busy_after_fill", busy, 1'b1);
    check("r_all", r_all, exp_r);
    check("g_all", g_all, exp_g);
    check("b_all", b_all, exp_b);
    if (lat) begin
      n = 1;
      while (!m_coef_valid && n < 40) begin
        @(negedge clk);
        #2;
        n++;
      end
      check("first_valid_latency", n, 9);
    end
    @(negedge clk);
  endtask

  task automatic wait_blocks(input int target);
    int g = 0;
    while (blocks_seen < target && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("blocks_completed", blocks_seen, target);
  endtask

  task automatic wait_words(input int target);
    int g = 0;
    while (words_seen < target && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("reached_word", words_seen, target);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {s_pix_ready, m_coef_valid, m_coef_last, busy, block_done,
                 m_coef_comp, block_count, m_coef_data}, '0);
    check({name, "_buses"}, r_all | g_all | b_all, '0);
  endtask

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b1;
    soft_clr    = 1'b0;
    s_pix_valid = 1'b0;
    s_pix_data  = '0;
    #12;
    check_all_zero("reset_state");
    @(negedge clk);
    reset_n = 1'b1;
    #2 check("ready_at_release", s_pix_ready, 1'b0);
    @(negedge clk);
    #2 check("ready_after_release", s_pix_ready, 1'b1);
    @(negedge clk);

    // Five back-to-back blocks; counter reads 1, 2, 3, 0, 1.
    fill_block(1'b0, 1'b0, 1'b1);
    for (int b = 0; b < 4; b++) fill_block(1'b0, 1'b0, 1'b0);
    wait_blocks(5);

    // Backpressure on both streams.
    rand_ready = 1'b1;
    fill_block(1'b1, 1'b0, 1'b0);
    wait_blocks(6);
    rand_ready = 1'b0;
    check("queue_drained", exp_q.size(), 0);

    // Enable drop during fill, then soft_clr at out_idx 100.
    fill_block(1'b0, 1'b1, 1'b0);
    wait_words(100);
    soft_clr = 1'b1;
    exp_q.delete();
    exp_cnt    = '0;
    words_seen = 0;
    @(negedge clk);
    soft_clr = 1'b0;
    #2;
    check("clr_valid", m_coef_valid, 1'b0);
    check("clr_count", block_count, '0);
    check("clr_busy", busy, 1'b0);
    check("clr_ready", s_pix_ready, 1'b1);
    @(negedge clk);

    // One clean block after the clear: count must be 1.
    fill_block(1'b0, 1'b0, 1'b0);
    wait_blocks(7);

    // Asynchronous reset in the middle of DRAIN.
    fill_block(1'b0, 1'b0, 1'b0);
    wait_words(50);
    #3 reset_n = 1'b0;
    #1 check_all_zero("reset_mid_drain");
    exp_q.delete();
    exp_cnt    = '0;
    words_seen = 0;
    @(negedge clk);
    reset_n = 1'b1;
    #2 check("ready_at_release2", s_pix_ready, 1'b0);
    @(negedge clk);
    #2 check("ready_after_release2", s_pix_ready, 1'b1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jpeg_block_scheduler.md
# jpeg_block_scheduler

Sequencer for the JPEG compression datapath. It accepts an RGB pixel stream, assembles one 8x8 block into the flat `r_all`/`g_all`/`b_all` buses and holds them stable while the pipeline settles. It then drains the pipeline's Y/Cb/Cr zigzag outputs as a single valid/ready coefficient stream. It sits between the DMA stream interface and the pipeline instance, replacing register-poked pixel loading with back-to-back block processing.

## Interface
- `DATA_WIDTH`, 32: width of one zigzag coefficient word.
- `INPUT_WIDTH`, 8: width of one colour channel sample.
- `PIXEL_COUNT`, 64: pixels per block.
- `PIPE_LATENCY`, 8: cycles from stable `r/g/b_all` to valid zigzag outputs; must be ≥1.
- `CNT_WIDTH`, 16: width of the block counter.
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: permits pixel acceptance.
- `soft_clr` in 1: synchronous abort and clear.
- `s_pix_data` in 3*INPUT_WIDTH: pixel packed as {B[23:16], G[15:8], R[7:0]}.
- `s_pix_valid` in 1: pixel stream valid.
- `s_pix_ready` out 1: pixel stream ready.
- `r_all`, `g_all`, `b_all` out INPUT_WIDTH*PIXEL_COUNT each: channel buses to the pipeline. Pixel i occupies `[INPUT_WIDTH*i +: INPUT_WIDTH]`.
- `y_zigzag`, `cb_zigzag`, `cr_zigzag` in DATA_WIDTH*PIXEL_COUNT each: pipeline outputs. Word k occupies `[DATA_WIDTH*k +: DATA_WIDTH]`.
- `m_coef_data` out DATA_WIDTH: coefficient word.
- `m_coef_comp` out 2: component of the current word; 0=Y, 1=Cb, 2=Cr.
- `m_coef_valid` out 1: coefficient stream valid.
- `m_coef_ready` in 1: coefficient stream ready.
- `m_coef_last` out 1: marks the final word of the block (index 3*PIXEL_COUNT-1).
- `busy` out 1: high in WAIT or DRAIN.
- `block_done` out 1: one-cycle pulse per completed block.
- `block_count` out CNT_WIDTH: number of completed blocks; wraps modulo 2^CNT_WIDTH.

## Operation
- **States:** FILL, WAIT, DRAIN. Reset enters FILL.
- **FILL**
  - `s_pix_ready` = `enable`, decoded combinationally from the registered state.
  - Each handshake (`s_pix_valid && s_pix_ready`) writes pixel `pix_idx` into `r/g/b_all`, then increments `pix_idx`.
  - The handshake at `pix_idx` = PIXEL_COUNT-1 moves the state to WAIT, clears `pix_idx`, and loads `wait_cnt` = PIPE_LATENCY-1.
- **WAIT**
  - `s_pix_ready` = 0.
  - `wait_cnt` decrements each cycle; at 0 the state moves to DRAIN with `out_idx` = 0.
- **DRAIN**
  - `m_coef_valid` = 1.
  - Word selection: `out_idx` 0..63 selects Y word `out_idx`, 64..127 selects Cb word `out_idx`-64, 128..191 selects Cr word `out_idx`-128.
  - `m_coef_data` and `m_coef_comp` are muxed combinationally from the registered `out_idx` and the held pipeline outputs.
  - Each handshake increments `out_idx`. The handshake at 191 (`m_coef_last`=1) does the following on the next edge:
    - pulses `block_done`;
    - increments `block_count`;
    - returns the state to FILL with `pix_idx` = 0.
- **Bus hold:** `r/g/b_all` change only on FILL handshakes, so they are stable throughout WAIT and DRAIN. Buffer contents persist across blocks and are overwritten pixel by pixel.
- **`enable` low:** only gates FILL acceptance and preserves `pix_idx`. It never aborts WAIT or DRAIN.
- **`soft_clr`:** highest priority. At the next edge it forces the state to FILL with `pix_idx` = `out_idx` = `wait_cnt` = 0 and `block_count` = 0. No `block_done` pulse is produced, and `r/g/b_all` are not cleared.
- **Stream rules:** while `m_coef_valid && !m_coef_ready`, `m_coef_data`, `m_coef_comp` and `m_coef_last` must hold stable. A valid signal is never withdrawn without a handshake, except on `soft_clr` or reset.

## Timing
- **Reset values:** all of the following are 0: state (FILL), all counters, `s_pix_ready`, `r/g/b_all`, `m_coef_valid`, `m_coef_data`, `m_coef_comp`, `m_coef_last`, `busy`, `block_done`, `block_count`.
- **Throughput:** one pixel per cycle in FILL; one coefficient per cycle in DRAIN with `m_coef_ready` held high.
- **Latency:** with the last pixel accepted at edge T, `busy` rises at T+1 and the first `m_coef_valid` appears at T+1+PIPE_LATENCY.
- **Block time:** with no stalls, one block takes 64 + PIPE_LATENCY + 192 cycles.
- **Completion:** `block_done` and the `block_count` update occur one cycle after the final handshake, coincident with `s_pix_ready` returning (if `enable`=1).
- **Reset mid-operation:** asynchronous return to reset values; any partial block is discarded.

## Test plan
- **Reset:** assert `reset_n`=0 mid-DRAIN. All outputs go to 0 immediately, and `s_pix_ready`=1 one cycle after release with `enable`=1.
- **Fill and drain:** fill pixel i = {3i, 2i, i} (B, G, R); the model returns Y word k = k, Cb = 0x100+k, Cr = 0x200+k.
  - `r_all[8i+:8]`=i.
  - Exactly 192 words are emitted in Y/Cb/Cr order with the expected `m_coef_comp` values.
  - `m_coef_last` is set only on 0x23F.
  - The first valid appears 9 cycles after the last pixel (PIPE_LATENCY=8).
  - `block_done` pulses once and `block_count`=1.
- **Backpressure:** random `m_coef_ready` at 50% and random gaps on `s_pix_valid`. Output is held stable during stalls and the word sequence is identical to the unstalled case.
- **Enable and clear:** drop `enable` after pixel 30; `s_pix_ready` falls in the same cycle and acceptance resumes at pixel 30. Then assert `soft_clr` at `out_idx`=100; `m_coef_valid`=0 next cycle, `block_count`=0, and no `block_done` pulse.
- **Counter wrap:** with CNT_WIDTH=2, run 5 back-to-back blocks. `block_count` reads 1, 2, 3, 0, 1 and there are no dead cycles other than WAIT.
